// File: rtl/chdr_pkt_stats.sv
// chdr_pkt_stats: CHDR packet sink that splits out the header and optional timestamp,
//   accumulates payload statistics and checks the header length field.
// Ports: clk/reset; i_t* 64-bit AXI-Stream slave; o_hdr/o_count/o_sum/o_min/o_max/o_crc/o_len_err
//   are the result register, qualified by o_valid and accepted with o_ready.
// Latency: result valid 1 cycle after the tlast beat. Backpressure: only a tlast beat stalls,
//   and only while an earlier result is still unaccepted.
module chdr_pkt_stats #(
  parameter logic [63:0] MIN_INIT = 64'h7FFF_FFFF_FFFF_FFFF,
  parameter logic [63:0] MAX_INIT = 64'h0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   i_tdata,
  input  logic          i_tlast,
  input  logic          i_tvalid,
  output logic          i_tready,
  output logic [127:0]  o_hdr,
  output logic [31:0]   o_count,
  output logic [63:0]   o_sum,
  output logic [63:0]   o_min,
  output logic [63:0]   o_max,
  output logic [63:0]   o_crc,
  output logic          o_len_err,
  output logic          o_valid,
  input  logic          o_ready
);

  typedef enum logic [1:0] {ST_HDR, ST_TIME, ST_BODY} state_t;

  state_t        state_q, state_d;
  logic [63:0]   hdr_q, hdr_d, ts_q, ts_d;
  logic [31:0]   count_q, count_d;
  logic [63:0]   sum_q, sum_d, min_q, min_d, max_q, max_d, crc_q, crc_d;
  logic [18:0]   nwords_q, nwords_d;

  logic [127:0]  res_hdr_q, res_hdr_d;
  logic [31:0]   res_count_q, res_count_d;
  logic [63:0]   res_sum_q, res_sum_d, res_min_q, res_min_d;
  logic [63:0]   res_max_q, res_max_d, res_crc_q, res_crc_d;
  logic          res_err_q, res_err_d, valid_q, valid_d;

  logic          beat;
  logic [63:0]   hdr_cur, ts_cur;
  logic [31:0]   count_n;
  logic [63:0]   sum_n, min_n, max_n, crc_n;
  logic [18:0]   nwords_n;
  logic [21:0]   nbytes, len_f;
  logic          len_ok, trunc;

  // A tlast beat is the only one that loads the result register, so it is the
  // only beat that has to wait for a pending result to be taken.
  assign i_tready = ~valid_q | o_ready | ~i_tlast;
  assign beat     = i_tvalid & i_tready;

  // View of the packet including the current beat, used when tlast closes it.
  always_comb begin
    hdr_cur  = (state_q == ST_HDR) ? i_tdata : hdr_q;
    ts_cur   = (state_q == ST_TIME) ? i_tdata : ((state_q == ST_HDR) ? 64'd0 : ts_q);
    count_n  = count_q;
    sum_n    = sum_q;
    crc_n    = crc_q;
    min_n    = min_q;
    max_n    = max_q;
    if (state_q == ST_BODY) begin
      count_n = count_q + 32'd1;
      sum_n   = sum_q + i_tdata;
      crc_n   = crc_q ^ i_tdata;
      min_n   = (i_tdata < min_q) ? i_tdata : min_q;
      max_n   = (i_tdata > max_q) ? i_tdata : max_q;
    end
    nwords_n = nwords_q + 19'd1;
    nbytes   = {nwords_n, 3'b000};
    len_f    = {6'd0, hdr_cur[47:32]};
    len_ok   = (len_f == nbytes) || (len_f == nbytes - 22'd4);
    // Timed packet ending on its header never delivered its timestamp.
    trunc    = (state_q == ST_HDR) && i_tdata[61];
  end

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    ts_d        = ts_q;
    count_d     = count_q;
    sum_d       = sum_q;
    min_d       = min_q;
    max_d       = max_q;
    crc_d       = crc_q;
    nwords_d    = nwords_q;
    res_hdr_d   = res_hdr_q;
    res_count_d = res_count_q;
    res_sum_d   = res_sum_q;
    res_min_d   = res_min_q;
    res_max_d   = res_max_q;
    res_crc_d   = res_crc_q;
    res_err_d   = res_err_q;
    valid_d     = valid_q & ~o_ready;
    if (beat) begin
      nwords_d = nwords_n;
      unique case (state_q)
        ST_HDR: begin
          hdr_d   = i_tdata;
          ts_d    = 64'd0;
          state_d = i_tdata[61] ? ST_TIME : ST_BODY;
        end
        ST_TIME: begin
          ts_d    = i_tdata;
          state_d = ST_BODY;
        end
        default: begin
          count_d = count_n;
          sum_d   = sum_n;
          crc_d   = crc_n;
          min_d   = min_n;
          max_d   = max_n;
          state_d = ST_BODY;
        end
      endcase
      if (i_tlast) begin
        res_hdr_d   = {hdr_cur, ts_cur};
        res_count_d = count_n;
        res_sum_d   = sum_n;
        res_min_d   = min_n;
        res_max_d   = max_n;
        res_crc_d   = crc_n;
        res_err_d   = ~len_ok | trunc;
        valid_d     = 1'b1;
        state_d     = ST_HDR;
        count_d     = 32'd0;
        sum_d       = 64'd0;
        crc_d       = 64'd0;
        min_d       = MIN_INIT;
        max_d       = MAX_INIT;
        nwords_d    = 19'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HDR;
      hdr_q       <= 64'd0;
      ts_q        <= 64'd0;
      count_q     <= 32'd0;
      sum_q       <= 64'd0;
      min_q       <= MIN_INIT;
      max_q       <= MAX_INIT;
      crc_q       <= 64'd0;
      nwords_q    <= 19'd0;
      res_hdr_q   <= 128'd0;
      res_count_q <= 32'd0;
      res_sum_q   <= 64'd0;
      res_min_q   <= 64'd0;
      res_max_q   <= 64'd0;
      res_crc_q   <= 64'd0;
      res_err_q   <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      ts_q        <= ts_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      min_q       <= min_d;
      max_q       <= max_d;
      crc_q       <= crc_d;
      nwords_q    <= nwords_d;
      res_hdr_q   <= res_hdr_d;
      res_count_q <= res_count_d;
      res_sum_q   <= res_sum_d;
      res_min_q   <= res_min_d;
      res_max_q   <= res_max_d;
      res_crc_q   <= res_crc_d;
      res_err_q   <= res_err_d;
      valid_q     <= valid_d;
    end
  end

  assign o_hdr     = res_hdr_q;
  assign o_count   = res_count_q;
  assign o_sum     = res_sum_q;
  assign o_min     = res_min_q;
  assign o_max     = res_max_q;
  assign o_crc     = res_crc_q;
  assign o_len_err = res_err_q;
  assign o_valid   = valid_q;

endmodule

// File: tb/tb_chdr_pkt_stats.sv
// tb_chdr_pkt_stats: drives CHDR packets into chdr_pkt_stats and scores each result
// against a reference computed from the packet words when they are sent.
// Results are popped from the expectation queue whenever a result handshake occurs.
module tb_chdr_pkt_stats;

  localparam logic [63:0] MIN_INIT = 64'h7FFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [127:0] hdr;
    logic [31:0]  count;
    logic [63:0]  sum;
    logic [63:0]  min;
    logic [63:0]  max;
    logic [63:0]  crc;
    logic         len_err;
  } res_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   i_tdata;
  logic          i_tlast, i_tvalid, i_tready;
  logic [127:0]  o_hdr;
  logic [31:0]   o_count;
  logic [63:0]   o_sum, o_min, o_max, o_crc;
  logic          o_len_err, o_valid, o_ready;
  logic          rdy_man, rdy_rnd, rnd_en;

  res_t          exp_q[$];
  res_t          mon_e;
  logic [63:0]   pkt[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_pushed = 0;
  int            n_results = 0;

  always #5 clk = ~clk;
  assign o_ready = rnd_en ? rdy_rnd : rdy_man;

  chdr_pkt_stats dut (
    .clk(clk), .reset(reset),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_hdr(o_hdr), .o_count(o_count), .o_sum(o_sum), .o_min(o_min), .o_max(o_max),
    .o_crc(o_crc), .o_len_err(o_len_err), .o_valid(o_valid), .o_ready(o_ready)
  );

  task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic res_t model();
    res_t r;
    int n, first, lenf;
    n     = pkt.size();
    first = pkt[0][61] ? 2 : 1;
    r.hdr   = {pkt[0], (pkt[0][61] && n > 1) ? pkt[1] : 64'd0};
    r.count = 0;
    r.sum   = 0;
    r.crc   = 0;
    r.min   = MIN_INIT;
    r.max   = 64'd0;
    for (int i = first; i < n; i++) begin
      r.count++;
      r.sum = r.sum + pkt[i];
      r.crc = r.crc ^ pkt[i];
      if (pkt[i] < r.min) r.min = pkt[i];
      if (pkt[i] > r.max) r.max = pkt[i];
    end
    lenf = int'(pkt[0][47:32]);
    r.len_err = !((lenf == 8 * n) || (lenf == 8 * n - 4)) || (pkt[0][61] && n == 1);
    return r;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Sends pkt; with close=1 the last word carries tlast and a result is expected.
  // Must be called at posedge+1.
  task automatic send_pkt(input bit close);
    int w;
    if (close) begin
      exp_q.push_back(model());
      n_pushed++;
    end
    for (int i = 0; i < pkt.size(); i++) begin
      i_tdata  = pkt[i];
      i_tvalid = 1'b1;
      i_tlast  = close && (i == pkt.size() - 1);
      w = 0;
      @(negedge clk);
      while (!i_tready && w < 200) begin
        w++;
        @(negedge clk);
      end
      if (!i_tready) chk_eq("tready_timeout", i_tready, 1);
      sync();
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        chk_eq("unexpected_result", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        n_results++;
        chk_eq("hdr", o_hdr, mon_e.hdr);
        chk_eq("count", o_count, mon_e.count);
        chk_eq("sum", o_sum, mon_e.sum);
        chk_eq("min", o_min, mon_e.min);
        chk_eq("max", o_max, mon_e.max);
        chk_eq("crc", o_crc, mon_e.crc);
        chk_eq("len_err", o_len_err, mon_e.len_err);
      end
    end
  end

  initial begin
    rdy_rnd = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_rnd = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, npay, ht, n, len;
    reset = 1'b1; i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
    rdy_man = 1'b1; rnd_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_valid", o_valid, 0);
    chk_eq("rst_tready", i_tready, 1);
    chk_eq("rst_hdr", o_hdr, 0);
    chk_eq("rst_count", o_count, 0);
    chk_eq("rst_min", o_min, 0);
    chk_eq("rst_len_err", o_len_err, 0);
    sync();
    reset = 1'b0;

    // Header-only packet, then the 1-cycle result latency.
    pkt = '{64'h0000_0008_0001_0002};
    send_pkt(1);
    @(negedge clk);
    chk_eq("t1_latency", o_valid, 1);
    sync();

    // Timed ramp.
    pkt = '{64'h2000_0030_0001_0002, 64'h100, 64'd1, 64'd2, 64'd3, 64'd4};
    send_pkt(1);

    // Length check, sent back to back.
    pkt = '{64'h0000_0020_0001_0002, 64'd7, 64'd8};
    send_pkt(1);
    pkt = '{64'h0000_0014_0001_0002, 64'd7, 64'd8};
    send_pkt(1);
    repeat (3) sync();

    // Backpressure: first result held, only the second tlast beat stalls.
    rdy_man = 1'b0;
    pkt = '{64'h0000_0010_0001_0003, 64'd5};
    send_pkt(1);
    pkt = '{64'h0000_0018_0001_0004, 64'd7, 64'd9};
    exp_q.push_back(model());
    n_pushed++;
    for (int i = 0; i < 2; i++) begin
      i_tdata = pkt[i]; i_tvalid = 1'b1; i_tlast = 1'b0;
      @(negedge clk);
      chk_eq("bp_body_tready", i_tready, 1);
      sync();
    end
    i_tdata = pkt[2]; i_tlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("bp_tlast_tready", i_tready, 0);
      chk_eq("bp_hold_valid", o_valid, 1);
      chk_eq("bp_hold_sum", o_sum, 64'd5);
    end
    sync();
    rdy_man = 1'b1;
    sync();
    rdy_man = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0;
    @(negedge clk);
    chk_eq("bp_next_valid", o_valid, 1);
    chk_eq("bp_next_sum", o_sum, 64'd16);
    sync();
    rdy_man = 1'b1;
    repeat (2) sync();

    // Reset in the middle of a packet.
    pkt = '{64'h0000_0018_0001_0002, 64'd11, 64'd12};
    send_pkt(0);
    reset = 1'b1;
    sync();
    reset = 1'b0;
    @(negedge clk);
    chk_eq("midrst_valid", o_valid, 0);
    sync();
    pkt = '{64'h2000_0030_0001_0002, 64'h100, 64'd1, 64'd2, 64'd3, 64'd4};
    send_pkt(1);

    // Truncated timed packet.
    pkt = '{64'h2000_0010_0001_0002};
    send_pkt(1);

    // Random packets with random result acceptance.
    rnd_en = 1'b1;
    for (int p = 0; p < 12; p++) begin
      ht   = int'($urandom_range(0, 1));
      npay = int'($urandom_range(0, 5));
      n    = 1 + ht + npay;
      len  = (p % 3 == 0) ? 8 * n - 4 : ((p % 3 == 1) ? 8 * n : 8 * n + 8);
      pkt.delete();
      pkt.push_back({2'b00, ht[0], 1'b0, 12'(p), 16'(len), 32'h0001_0002});
      for (int k = 1; k < n; k++) pkt.push_back({$urandom, $urandom});
      send_pkt(1);
    end
    rnd_en = 1'b0;
    rdy_man = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      w++;
      sync();
    end
    chk_eq("drain_results", n_results, n_pushed);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
